// File: rtl/heap_sift_ctrl.sv
// Replace-top sift-down sequencer for a BRAM-backed max-heap; owns the single memory port per operation.
// Optional HEAP_SIFT_STATS_EN adds the sift_levels output (swap count of the last operation).
module heap_sift_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH:0]   heap_size,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef HEAP_SIFT_STATS_EN
    ,
    output logic [ADDR_WIDTH-1:0] sift_levels
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_L,
        S_READ_R,
        S_CMP,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   carry_q;
    logic [DATA_WIDTH-1:0]   left_q;
    logic [DATA_WIDTH-1:0]   pend_data_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ADDR_WIDTH-1:0]   pend_addr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    right_abs_q;
    logic                    pend_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rd_q;
    logic                    wr_q;

    logic [ADDR_WIDTH:0]     lidx_d;
    logic [ADDR_WIDTH:0]     ridx_d;
    logic [ADDR_WIDTH:0]     next_left_d;
    logic [DATA_WIDTH-1:0]   right_val_d;
    logic [DATA_WIDTH-1:0]   win_val_d;
    logic [ADDR_WIDTH-1:0]   win_idx_d;
    logic                    go_left_d;
    logic                    swap_d;
    logic                    leaf_d;
    logic                    next_leaf_d;
    logic                    to_done_d;

    always_comb begin
        lidx_d      = {idx_q, 1'b1};
        ridx_d      = lidx_d + (ADDR_WIDTH+1)'(1);
        leaf_d      = (lidx_d >= heap_size);
        right_val_d = right_abs_q ? '0 : mem_rdata;
        go_left_d   = (left_q >= right_val_d);
        swap_d      = go_left_d ? (carry_q < left_q) : (carry_q <= right_val_d);
        win_idx_d   = go_left_d ? lidx_d[ADDR_WIDTH-1:0] : ridx_d[ADDR_WIDTH-1:0];
        win_val_d   = go_left_d ? left_q : right_val_d;
        next_left_d = (state_q == S_IDLE) ? (ADDR_WIDTH+1)'(1) : {win_idx_d, 1'b1};
        next_leaf_d = (next_left_d >= heap_size);
        to_done_d   = ((state_q == S_READ_L) && leaf_d) || ((state_q == S_CMP) && !swap_d);
    end

    // A swap's write cannot share the next level's READ_L slot (left read), so it is
    // held pending and issued in the next free slot: that level's CMP cycle, or its
    // READ_L cycle when the new node is a leaf. Write order and per-level count are unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            carry_q     <= '0;
            left_q      <= '0;
            pend_data_q <= '0;
            wdata_q     <= '0;
            idx_q       <= '0;
            pend_addr_q <= '0;
            addr_q      <= '0;
            right_abs_q <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        carry_q <= in_data;
                        idx_q   <= '0;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_READ_L;
                        if (!next_leaf_d) begin
                            rd_q   <= 1'b1;
                            addr_q <= next_left_d[ADDR_WIDTH-1:0];
                        end
                    end
                end
                S_READ_L: begin
                    if (leaf_d) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= idx_q;
                        wdata_q <= carry_q;
                    end else begin
                        state_q     <= S_READ_R;
                        right_abs_q <= (ridx_d >= heap_size);
                        if (ridx_d < heap_size) begin
                            rd_q   <= 1'b1;
                            addr_q <= ridx_d[ADDR_WIDTH-1:0];
                        end
                    end
                end
                S_READ_R: begin
                    left_q  <= mem_rdata;
                    state_q <= S_CMP;
                    if (pend_q) begin
                        wr_q    <= 1'b1;
                        addr_q  <= pend_addr_q;
                        wdata_q <= pend_data_q;
                        pend_q  <= 1'b0;
                    end
                end
                S_CMP: begin
                    if (swap_d) begin
                        idx_q   <= win_idx_d;
                        state_q <= S_READ_L;
                        if (next_leaf_d) begin
                            wr_q    <= 1'b1;
                            addr_q  <= idx_q;
                            wdata_q <= win_val_d;
                        end else begin
                            rd_q        <= 1'b1;
                            addr_q      <= next_left_d[ADDR_WIDTH-1:0];
                            pend_q      <= 1'b1;
                            pend_addr_q <= idx_q;
                            pend_data_q <= win_val_d;
                        end
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= idx_q;
                        wdata_q <= carry_q;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef HEAP_SIFT_STATS_EN
    logic [ADDR_WIDTH-1:0] lvl_cnt_q;
    logic [ADDR_WIDTH-1:0] sift_levels_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_cnt_q     <= '0;
            sift_levels_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                lvl_cnt_q <= '0;
            end else if ((state_q == S_CMP) && swap_d) begin
                lvl_cnt_q <= lvl_cnt_q + 1'b1;
            end
            if (to_done_d) begin
                sift_levels_q <= lvl_cnt_q;
            end
        end
    end

    assign sift_levels = sift_levels_q;
`else
    logic unused_to_done;
    assign unused_to_done = to_done_d;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_q;
    assign mem_wr_en = wr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_heap_sift_ctrl.sv
// Directed bench for heap_sift_ctrl with a 1-cycle-latency BRAM model and write log.
module tb_heap_sift_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW:0]   heap_size = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef HEAP_SIFT_STATS_EN
    logic [AW-1:0] sift_levels;
`endif

    heap_sift_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .heap_size (heap_size),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef HEAP_SIFT_STATS_EN
        ,
        .sift_levels (sift_levels)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] init_v [0:15];
    logic          ld = 1'b0;
    int            wa [$];
    logic [DW-1:0] wd [$];
    int            dcount = 0;
    int            rd2 = 0;
    int            coll = 0;

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_v[i];
        end else begin
            if (mem_rd_en === 1'b1) mem_rdata <= mem[mem_addr];
            if (mem_wr_en === 1'b1) begin
                mem[mem_addr] <= mem_wdata;
                wa.push_back(int'(mem_addr));
                wd.push_back(mem_wdata);
            end
            if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) coll++;
            if (mem_rd_en === 1'b1 && mem_addr == 10'd2) rd2++;
        end
        if (done === 1'b1) dcount++;
    end

    int checks = 0;
    int passed = 0;
    int wbase, dbase, rbase, ncyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load5(input logic [DW-1:0] a, b, c, d, e);
        for (int i = 0; i < 16; i++) init_v[i] = '0;
        init_v[0] = a; init_v[1] = b; init_v[2] = c; init_v[3] = d; init_v[4] = e;
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic run_op(input logic [AW:0] size, input logic [DW-1:0] din,
                          input int glitch, output int n);
        wbase = wa.size();
        dbase = dcount;
        rbase = rd2;
        @(negedge clk);
        heap_size = size; in_data = din; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (n == glitch) begin
                start = 1'b1; in_data = 32'h99;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_wr(input string tag, input int k, input int a, input logic [DW-1:0] d);
        if (wa.size() > wbase + k) begin
            chk({tag, "_addr"}, 64'(wa[wbase+k]), 64'(a));
            chk({tag, "_data"}, 64'(wd[wbase+k]), 64'(d));
        end else begin
            chk({tag, "_present"}, 64'(wa.size() - wbase), 64'(k + 1));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {60'd0, busy, done, mem_rd_en, mem_wr_en}, 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Two swaps then leaf
        load5(50, 40, 30, 20, 10);
        run_op(11'd5, 32'd5, 0, ncyc);
        chk("sift2_done_cyc", 64'(ncyc), 64'd8);
        chk("sift2_busy_after", 64'(busy), 64'd0);
        chk("sift2_nwr", 64'(wa.size() - wbase), 64'd3);
        chk_wr("sift2_w0", 0, 0, 40);
        chk_wr("sift2_w1", 1, 1, 20);
        chk_wr("sift2_w2", 2, 3, 5);
        chk("sift2_mem", {mem[0][15:0], mem[1][15:0], mem[2][15:0], mem[3][15:0]},
            {16'd40, 16'd20, 16'd30, 16'd5});
        chk("sift2_mem4", 64'(mem[4]), 64'd10);
`ifdef HEAP_SIFT_STATS_EN
        chk("sift2_levels", 64'(sift_levels), 64'd2);
`endif

        // No swap at root
        load5(50, 40, 30, 20, 10);
        run_op(11'd5, 32'd60, 0, ncyc);
        chk("noswap_done_cyc", 64'(ncyc), 64'd4);
        chk("noswap_nwr", 64'(wa.size() - wbase), 64'd1);
        chk_wr("noswap_w0", 0, 0, 60);

        // Tie with left child: no swap
        load5(9, 7, 7, 0, 0);
        run_op(11'd3, 32'd7, 0, ncyc);
        chk("tie_done_cyc", 64'(ncyc), 64'd4);
        chk("tie_nwr", 64'(wa.size() - wbase), 64'd1);
        chk_wr("tie_w0", 0, 0, 7);

        // Right child absent
        load5(9, 8, 77, 0, 0);
        run_op(11'd2, 32'd3, 0, ncyc);
        chk("size2_done_cyc", 64'(ncyc), 64'd5);
        chk("size2_rd_addr2", 64'(rd2 - rbase), 64'd0);
        chk("size2_nwr", 64'(wa.size() - wbase), 64'd2);
        chk_wr("size2_w0", 0, 0, 8);
        chk_wr("size2_w1", 1, 1, 3);
`ifdef HEAP_SIFT_STATS_EN
        chk("size2_levels", 64'(sift_levels), 64'd1);
`endif

        // Empty heap
        run_op(11'd0, 32'h1234, 0, ncyc);
        chk("empty_done_cyc", 64'(ncyc), 64'd2);
        chk("empty_nwr", 64'(wa.size() - wbase), 64'd1);
        chk_wr("empty_w0", 0, 0, 32'h1234);

        // start while busy is ignored
        load5(50, 40, 30, 20, 10);
        run_op(11'd5, 32'd5, 3, ncyc);
        repeat (6) @(posedge clk);
        #1;
        chk("glitch_done_cyc", 64'(ncyc), 64'd8);
        chk("glitch_ndone", 64'(dcount - dbase), 64'd1);
        chk("glitch_nwr", 64'(wa.size() - wbase), 64'd3);
        chk("glitch_busy", 64'(busy), 64'd0);
        chk_wr("glitch_w2", 2, 3, 5);

        // Reset mid-operation
        load5(50, 40, 30, 20, 10);
        dbase = dcount;
        @(negedge clk);
        heap_size = 11'd5; in_data = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        wbase = wa.size();
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {60'd0, busy, done, mem_rd_en, mem_wr_en}, 64'd0);
        chk("midrst_addr_wdata", {32'(mem_addr), mem_wdata}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_nwr_after", 64'(wa.size() - wbase), 64'd0);
        chk("midrst_ndone", 64'(dcount - dbase), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);

        chk("port_collisions", 64'(coll), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
